// File: rtl/mem_rd_arbiter_pkg.sv
// mem_rd_arbiter_pkg: shared types for the read-channel arbiter
package mem_rd_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_arb_state_e;
endpackage

// File: rtl/mem_rd_arbiter_rr_pick.sv
// rr_pick: round-robin winner via rotate, lowest-set-bit encode, rotate back
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = W'(i);
  end
  assign any = |req;
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one AR/R read channel between N_REQ requesters,
// one outstanding burst at a time, round-robin with a registered grant.
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 8,
  parameter int RESP_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            s_arvalid,
  output logic [N_REQ-1:0]            s_arready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [N_REQ*LEN_WIDTH-1:0]  s_arlen,
  output logic [N_REQ-1:0]            s_rvalid,
  input  logic [N_REQ-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]       s_rdata,
  output logic [RESP_WIDTH-1:0]       s_rresp,
  output logic                        s_rlast,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [LEN_WIDTH-1:0]        m_arlen,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [DATA_WIDTH-1:0]       m_rdata,
  input  logic [RESP_WIDTH-1:0]       m_rresp,
  input  logic                        m_rlast
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  rd_arb_state_e   state_q;
  logic [GW-1:0]   grant_q, rr_q, rr_d, pick_idx;
  logic [N_REQ-1:0] sel;
  logic            pick_any, in_addr, in_data, ar_hs, r_done;
  rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .req(s_arvalid),
    .ptr(rr_q),
    .any(pick_any),
    .idx(pick_idx)
  );
  assign in_addr   = state_q == ADDR;
  assign in_data   = state_q == DATA;
  assign sel       = N_REQ'(1) << grant_q;
  assign m_arvalid = in_addr & s_arvalid[grant_q];
  assign m_araddr  = in_addr ? s_araddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign m_arlen   = in_addr ? s_arlen[grant_q*LEN_WIDTH +: LEN_WIDTH] : '0;
  assign s_arready = (in_addr && m_arready) ? sel : '0;
  assign m_rready  = in_data & s_rready[grant_q];
  assign s_rvalid  = (in_data && m_rvalid) ? sel : '0;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign ar_hs     = m_arvalid & m_arready;
  assign r_done    = m_rvalid & m_rready & m_rlast;
  assign rr_d      = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_any) begin
          grant_q <= pick_idx;
          state_q <= ADDR;
        end
        ADDR: if (ar_hs) state_q <= DATA;
        DATA: if (r_done) begin
          state_q <= IDLE;
          rr_q    <= rr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  // A granted requester must hold arvalid until its address is accepted.
  a_ar_hold: assert property (@(posedge clk) disable iff (!rst_n) in_addr |-> s_arvalid[grant_q]);
  a_rvalid_oh: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(s_rvalid));
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed and randomized checks against a round-robin model
module tb_mem_rd_arbiter;
  import mem_rd_arbiter_pkg::*;
  localparam int N = 2, AW = 32, DW = 128, LW = 8, RW = 4;
  logic clk = 1'b0, rst_n;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*LW-1:0] s_arlen;
  logic [DW-1:0]   s_rdata, m_rdata;
  logic [RW-1:0]   s_rresp, m_rresp;
  logic            s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [AW-1:0]   m_araddr;
  logic [LW-1:0]   m_arlen;
  int total = 0, bad = 0, rr_m = 0;

  mem_rd_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RESP_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  initial forever #5 clk = ~clk;

  function automatic int rr_scan(logic [N-1:0] req, int ptr);
    for (int i = 0; i < N; i++)
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic clear_inputs();
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    rr_m = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if ({s_arready, s_rvalid, m_arvalid, m_rready, m_araddr, m_arlen} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ar=%b rv=%b mav=%b mrr=%b addr=%h exp all 0",
               s_arready, s_rvalid, m_arvalid, m_rready, m_araddr);
    end
    total++;
    if (dut.state_q !== IDLE || dut.rr_q !== 0) begin
      bad++; $display("FAIL reset_state got st=%0d rr=%0d exp 0/0", dut.state_q, dut.rr_q);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
    @(negedge clk);
    s_arvalid = 2'b01; s_araddr[AW-1:0] = 32'h8000_0040; s_arlen[LW-1:0] = '0; m_arready = 1;
    #1; total++;
    if (m_arvalid !== 1'b0) begin bad++; $display("FAIL single_idle got mav=%b exp 0", m_arvalid); end
    @(negedge clk); #1; total++;
    if ({m_arvalid, m_araddr, m_arlen, s_arready} !== {1'b1, 32'h8000_0040, 8'h00, 2'b01}) begin
      bad++; $display("FAIL single_addr got mav=%b addr=%h len=%h ar=%b exp 1/80000040/0/01",
                      m_arvalid, m_araddr, m_arlen, s_arready);
    end
    @(negedge clk);
    s_arvalid = '0; m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rdata = d; s_rready = 2'b01;
    #1; total++;
    if ({s_rvalid, m_rready, s_rlast} !== 4'b0111 || s_rdata !== d) begin
      bad++; $display("FAIL single_data got rv=%b mrr=%b last=%b data=%h exp 01/1/1/%h",
                      s_rvalid, m_rready, s_rlast, s_rdata, d);
    end
    @(negedge clk);
    clear_inputs();
    rr_m = 1;
    #1; total++;
    if (dut.state_q !== IDLE || dut.rr_q !== 1'(rr_m)) begin
      bad++; $display("FAIL single_done got st=%0d rr=%0d exp IDLE/%0d", dut.state_q, dut.rr_q, rr_m);
    end
  endtask

  task automatic test_simultaneous();
    int w;
    logic [N-1:0] oh;
    apply_reset();
    s_arvalid = 2'b11; s_araddr = {32'h1111_0000, 32'h0000_2222}; m_arready = 1; s_rready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = rr_scan(2'b11, rr_m);
      oh = '0; oh[w] = 1'b1;
      #1; total++;
      if (m_arvalid !== 1'b0) begin bad++; $display("FAIL simul_idle%0d got mav=%b exp 0", k, m_arvalid); end
      @(negedge clk); #1; total++;
      if (m_arvalid !== 1'b1 || s_arready !== oh || m_araddr !== s_araddr[w*AW +: AW] || w != k % 2) begin
        bad++; $display("FAIL simul_grant%0d got ar=%b addr=%h exp ar=%b", k, s_arready, m_araddr, oh);
      end
      @(negedge clk);
      m_rvalid = 1; m_rlast = 1;
      #1; total++;
      if (s_rvalid !== oh) begin bad++; $display("FAIL simul_r%0d got rv=%b exp %b", k, s_rvalid, oh); end
      @(negedge clk);
      m_rvalid = 0; m_rlast = 0;
      rr_m = (w + 1) % N;
    end
    clear_inputs();
  endtask

  task automatic test_burst_and_wait();
    logic [DW-1:0] bd [4];
    int beat = 0, c = 0;
    for (int i = 0; i < 4; i++) bd[i] = {$urandom, $urandom, $urandom, $urandom};
    s_arvalid = 2'b10; s_araddr[AW +: AW] = 32'hA000_0100; s_arlen[LW +: LW] = 8'd3; m_arready = 1;
    @(negedge clk); #1; total++;
    if ({m_arvalid, m_araddr, m_arlen, s_arready} !== {1'b1, 32'hA000_0100, 8'd3, 2'b10}) begin
      bad++; $display("FAIL burst_addr got mav=%b addr=%h len=%0d ar=%b", m_arvalid, m_araddr, m_arlen, s_arready);
    end
    @(negedge clk);
    s_arvalid = '0; m_arready = 0;
    while (beat < 4 && c < 20) begin
      s_rready = {!(c == 2 || c == 3), 1'b0};
      if (c == 1) begin s_arvalid = 2'b01; s_araddr[AW-1:0] = 32'h0000_0BC0; end
      m_rvalid = 1; m_rdata = bd[beat]; m_rlast = (beat == 3);
      #1; total++;
      if (m_rready !== s_rready[1] || s_rvalid !== 2'b10 || s_rdata !== bd[beat] ||
          s_arready !== '0 || m_arvalid !== 1'b0 || dut.state_q !== DATA) begin
        bad++; $display("FAIL burst_beat%0d c=%0d got mrr=%b rv=%b ar=%b mav=%b st=%0d",
                        beat, c, m_rready, s_rvalid, s_arready, m_arvalid, dut.state_q);
      end
      if (s_rready[1]) beat++;
      c++;
      @(negedge clk);
    end
    m_rvalid = 0; m_rlast = 0; s_rready = '0; m_arready = 1;
    rr_m = 0;
    #1; total++;
    if (dut.state_q !== IDLE || s_arready !== '0 || m_arvalid !== 1'b0 || c != 6) begin
      bad++; $display("FAIL burst_end got st=%0d ar=%b mav=%b cycles=%0d exp IDLE/0/0/6",
                      dut.state_q, s_arready, m_arvalid, c);
    end
    @(negedge clk); #1; total++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_0BC0 || s_arready !== 2'b01) begin
      bad++; $display("FAIL wait_grant got mav=%b addr=%h ar=%b exp 1/00000bc0/01", m_arvalid, m_araddr, s_arready);
    end
    @(negedge clk);
    s_arvalid = '0; m_arready = 0; m_rvalid = 1; m_rlast = 1; s_rready = 2'b01;
    #1; total++;
    if (s_rvalid !== 2'b01) begin bad++; $display("FAIL wait_r got rv=%b exp 01", s_rvalid); end
    @(negedge clk);
    clear_inputs();
    rr_m = 1;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a = $urandom;
    s_arvalid = 2'b01; s_araddr[AW-1:0] = a;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1; total++;
      if (m_arvalid !== 1'b1 || m_araddr !== a || s_arready !== '0) begin
        bad++; $display("FAIL bp_hold%0d got mav=%b addr=%h ar=%b exp 1/%h/00", i, m_arvalid, m_araddr, s_arready, a);
      end
      @(negedge clk);
    end
    m_arready = 1;
    #1; total++;
    if (s_arready !== 2'b01 || m_araddr !== a) begin
      bad++; $display("FAIL bp_accept got ar=%b addr=%h exp 01/%h", s_arready, m_araddr, a);
    end
    @(negedge clk);
    s_arvalid = '0; m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rresp = 4'h2; s_rready = 2'b01;
    #1; total++;
    if (s_rresp !== 4'h2 || s_rvalid !== 2'b01) begin
      bad++; $display("FAIL bp_slverr got resp=%h rv=%b exp 2/01", s_rresp, s_rvalid);
    end
    @(negedge clk);
    clear_inputs();
    rr_m = 1;
  endtask

  task automatic test_random();
    logic [N-1:0]  pend = '0, oh;
    logic [AW-1:0] am [N];
    logic [LW-1:0] lm [N];
    int w, stall, beat, guard;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1; am[i] = $urandom; lm[i] = LW'($urandom_range(0, 3));
        end
      if (pend == '0) begin pend[0] = 1; am[0] = $urandom; lm[0] = '0; end
      for (int i = 0; i < N; i++) begin s_araddr[i*AW +: AW] = am[i]; s_arlen[i*LW +: LW] = lm[i]; end
      s_arvalid = pend;
      #1; total++;
      if (m_arvalid !== 1'b0 || s_arready !== '0) begin
        bad++; $display("FAIL rnd_idle t=%0d got mav=%b ar=%b exp 0/0", t, m_arvalid, s_arready);
      end
      w = rr_scan(pend, rr_m);
      oh = '0; oh[w] = 1'b1;
      @(negedge clk);
      stall = $urandom_range(0, 2);
      do begin
        m_arready = (stall == 0);
        #1; total++;
        if (m_arvalid !== 1'b1 || m_araddr !== am[w] || m_arlen !== lm[w] || s_arready !== (m_arready ? oh : '0)) begin
          bad++; $display("FAIL rnd_addr t=%0d got mav=%b addr=%h len=%0d ar=%b exp addr=%h len=%0d ar=%b",
                          t, m_arvalid, m_araddr, m_arlen, s_arready, am[w], lm[w], m_arready ? oh : '0);
        end
        stall--;
        @(negedge clk);
      end while (stall >= 0);
      pend[w] = 0; s_arvalid = pend; m_arready = 0;
      beat = 0; guard = 0;
      while (beat <= int'(lm[w]) && guard < 60) begin
        if (!pend[N-1-w] && $urandom_range(0, 3) == 0) begin
          pend[N-1-w] = 1; am[N-1-w] = $urandom; lm[N-1-w] = LW'($urandom_range(0, 3));
          s_araddr[(N-1-w)*AW +: AW] = am[N-1-w]; s_arlen[(N-1-w)*LW +: LW] = lm[N-1-w];
          s_arvalid = pend;
        end
        m_rvalid = $urandom_range(0, 3) != 0; m_rdata = {$urandom, $urandom, $urandom, $urandom};
        m_rresp = RW'($urandom); m_rlast = (beat == int'(lm[w])); s_rready = N'($urandom);
        #1; total++;
        if (s_rvalid !== (m_rvalid ? oh : '0) || m_rready !== s_rready[w] || s_rdata !== m_rdata ||
            s_rresp !== m_rresp || s_rlast !== m_rlast || m_arvalid !== 1'b0 || s_arready !== '0) begin
          bad++; $display("FAIL rnd_data t=%0d b=%0d got rv=%b mrr=%b mav=%b ar=%b exp rv=%b mrr=%b",
                          t, beat, s_rvalid, m_rready, m_arvalid, s_arready, m_rvalid ? oh : '0, s_rready[w]);
        end
        if (m_rvalid && s_rready[w]) beat++;
        guard++;
        @(negedge clk);
      end
      m_rvalid = 0; m_rlast = 0; s_rready = '0;
      rr_m = (w + 1) % N;
    end
    #1; total++;
    if (dut.rr_q !== 1'(rr_m)) begin bad++; $display("FAIL rnd_rr got %0d exp %0d", dut.rr_q, rr_m); end
    while (pend != '0) begin
      w = rr_scan(pend, rr_m);
      pend[w] = 0;
      @(negedge clk); m_arready = 1;
      @(negedge clk); s_arvalid = pend; m_arready = 0; m_rvalid = 1; m_rlast = 1; s_rready = '1;
      @(negedge clk); m_rvalid = 0; m_rlast = 0; s_rready = '0;
      rr_m = (w + 1) % N;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    s_arvalid = 2'b10; s_araddr[AW +: AW] = 32'h4000_0000; s_arlen[LW +: LW] = 8'd3; m_arready = 1;
    @(negedge clk);
    @(negedge clk);
    s_arvalid = '0; m_arready = 0; m_rvalid = 1; m_rlast = 0; s_rready = 2'b10;
    #1; total++;
    if (s_rvalid !== 2'b10 || m_rready !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got rv=%b mrr=%b exp 10/1", s_rvalid, m_rready);
    end
    @(negedge clk);
    #1 s_arvalid = 2'b01; m_arready = 1;
    #2 rst_n = 0;
    #1; total++;
    if ({s_arready, s_rvalid, m_arvalid, m_rready} !== '0) begin
      bad++; $display("FAIL rstmid_async got ar=%b rv=%b mav=%b mrr=%b exp all 0", s_arready, s_rvalid, m_arvalid, m_rready);
    end
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    rr_m = 0;
    #1; total++;
    if (dut.state_q !== IDLE || dut.rr_q !== 1'(rr_m) || m_arvalid !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got st=%0d rr=%0d mav=%b exp IDLE/0/0", dut.state_q, dut.rr_q, m_arvalid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_burst_and_wait();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
